simon_key_sched_ctrl: RTL and testbench



---
 rtl/simon_key_sched_ctrl_pkg.sv | 21 ++
 rtl/simon_key_sched_ctrl_if.sv | 34 +++
 rtl/simon_ks_step.sv | 17 +
 rtl/simon_key_sched_ctrl.sv | 118 +++++++++++
 tb/tb_simon_key_sched_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/simon_key_sched_ctrl_pkg.sv
// Shared constants, types and state encoding for the SIMON64/128 key-schedule controller.
package simon_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned KEY_WORDS  = 4;
  localparam int unsigned NUM_ROUNDS = 44;

  localparam logic [31:0] SIMON_C = 32'hFFFFFFFC;
  // Leftmost character of the z3 sequence is bit 61 here, so z3[j] = Z3[61-j].
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [5:0]        rk_idx_t;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

  function automatic logic z3_bit(input rk_idx_t j);
    return Z3[6'd61 - j];
  endfunction

endpackage

// File: rtl/simon_key_sched_ctrl_if.sv
// Key-load handshake and round-key read bus; stream outputs exist only with SIMON_KS_STREAM_EN.
interface simon_key_sched_ctrl_if;
  import simon_pkg::*;

  logic           key_valid;
  logic           key_ready;
  logic [127:0]   key_in;
  logic           busy;
  logic           keys_valid;
  rk_idx_t        rk_addr;
  word_t          rk_rdata;
`ifdef SIMON_KS_STREAM_EN
  logic           rk_stream_valid;
  rk_idx_t        rk_stream_idx;
  word_t          rk_stream_data;
`endif

  modport slave (
    input  key_valid, key_in, rk_addr,
`ifdef SIMON_KS_STREAM_EN
    output rk_stream_valid, rk_stream_idx, rk_stream_data,
`endif
    output key_ready, busy, keys_valid, rk_rdata
  );

  modport master (
    output key_valid, key_in, rk_addr,
`ifdef SIMON_KS_STREAM_EN
    input  rk_stream_valid, rk_stream_idx, rk_stream_data,
`endif
    input  key_ready, busy, keys_valid, rk_rdata
  );

endinterface

// File: rtl/simon_ks_step.sv
// One SIMON64/128 key-schedule step: new = C ^ z ^ W0 ^ T ^ ror(T,1), T = W1 ^ ror(W3,3).
module simon_ks_step
  import simon_pkg::*;
(
  input  word_t w0_i,
  input  word_t w1_i,
  input  word_t w3_i,
  input  logic  zbit_i,
  output word_t new_o
);

  word_t t;

  assign t     = w1_i ^ {w3_i[2:0], w3_i[31:3]};
  assign new_o = SIMON_C ^ {31'b0, zbit_i} ^ w0_i ^ t ^ {t[0], t[31:1]};

endmodule

// File: rtl/simon_key_sched_ctrl.sv
// SIMON64/128 key-expansion sequencer with 44x32 round-key buffer and registered read port.
// Optional macro SIMON_KS_STREAM_EN adds a streamed copy of every buffer write.
module simon_key_sched_ctrl
  import simon_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  simon_key_sched_ctrl_if.slave bus
);

  state_e  state_q;
  rk_idx_t cnt_q;
  word_t   win_q [KEY_WORDS];
  word_t   buf_q [NUM_ROUNDS];
  logic    key_ready_q, busy_q, keys_valid_q;
  word_t   rdata_q;
  word_t   new_word;
  logic    accept;

  assign accept = bus.key_valid && key_ready_q;

  simon_ks_step u_step (
    .w0_i   (win_q[0]),
    .w1_i   (win_q[1]),
    .w3_i   (win_q[3]),
    .zbit_i (z3_bit(cnt_q - 6'd4)),
    .new_o  (new_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      rdata_q <= (bus.rk_addr < 6'(NUM_ROUNDS)) ? buf_q[bus.rk_addr] : '0;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            for (int unsigned i = 0; i < KEY_WORDS; i++) win_q[i] <= bus.key_in[32*i +: 32];
            cnt_q        <= 6'(KEY_WORDS);
            state_q      <= EXPAND;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            keys_valid_q <= 1'b0;
          end else if (state_q == DONE) begin
            // keys_valid trails the final write by one edge
            keys_valid_q <= 1'b1;
          end
        end
        EXPAND: begin
          win_q[0] <= win_q[1];
          win_q[1] <= win_q[2];
          win_q[2] <= win_q[3];
          win_q[3] <= new_word;
          cnt_q    <= cnt_q + 6'd1;
          if (cnt_q == 6'(NUM_ROUNDS - 1)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            key_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < KEY_WORDS; i++) buf_q[i] <= bus.key_in[32*i +: 32];
    end else if (state_q == EXPAND) begin
      buf_q[cnt_q] <= new_word;
    end
  end

  assign bus.key_ready  = key_ready_q;
  assign bus.busy       = busy_q;
  assign bus.keys_valid = keys_valid_q;
  assign bus.rk_rdata   = rdata_q;

`ifdef SIMON_KS_STREAM_EN
  // Streaming reads the buffer one entry behind its own counter; after the four
  // master words land together, the stream trails the writer by four cycles.
  logic    str_act_q, str_valid_q;
  rk_idx_t str_idx_q, str_out_idx_q;
  word_t   str_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      str_act_q     <= 1'b0;
      str_idx_q     <= '0;
      str_valid_q   <= 1'b0;
      str_out_idx_q <= '0;
      str_data_q    <= '0;
    end else if (accept) begin
      str_act_q   <= 1'b1;
      str_idx_q   <= '0;
      str_valid_q <= 1'b0;
    end else if (str_act_q) begin
      str_valid_q   <= 1'b1;
      str_out_idx_q <= str_idx_q;
      str_data_q    <= buf_q[str_idx_q];
      str_idx_q     <= str_idx_q + 6'd1;
      if (str_idx_q == 6'(NUM_ROUNDS - 1)) str_act_q <= 1'b0;
    end else begin
      str_valid_q <= 1'b0;
    end
  end

  assign bus.rk_stream_valid = str_valid_q;
  assign bus.rk_stream_idx   = str_out_idx_q;
  assign bus.rk_stream_data  = str_data_q;
`endif

endmodule

// File: tb/tb_simon_key_sched_ctrl.sv
// Self-checking bench for simon_key_sched_ctrl against a textbook SIMON64/128 key-schedule model.
module tb_simon_key_sched_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simon_key_sched_ctrl_if bus();

  simon_key_sched_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY_REF  = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [127:0] KEY_ZERO = '0;
  string z3s = "11011011101011000110010111100000010010001010011100110100001111";

  logic [31:0] mk [44];

  typedef struct {
    logic [127:0] key;
    logic [5:0]   addr;
    logic [31:0]  exp;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [31:0] ror(input logic [31:0] x, input int r);
    return (x >> r) | (x << (32 - r));
  endfunction

  // k[i] = ~k[i-4] ^ 3 ^ z[i-4] ^ tmp ^ ror(tmp,1), tmp = ror(k[i-1],3) ^ k[i-3]
  task automatic build_model(input logic [127:0] k);
    logic [31:0] tmp;
    logic        z;
    for (int i = 0; i < 4; i++) mk[i] = k[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      tmp   = ror(mk[i-1], 3) ^ mk[i-3];
      tmp   = tmp ^ ror(tmp, 1);
      z     = (z3s[i-4] == "1");
      mk[i] = ~mk[i-4] ^ 32'd3 ^ {31'd0, z} ^ tmp;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_addr(input logic [5:0] a, output logic [31:0] d);
    bus.rk_addr = a;
    tick();
    d = bus.rk_rdata;
  endtask

  task automatic sweep(input string tag);
    logic [31:0] d;
    for (int a = 0; a < 44; a++) begin
      read_addr(6'(a), d);
      check($sformatf("%s_addr%0d", tag, a), {32'd0, d}, {32'd0, mk[a]});
    end
    read_addr(6'd44, d);
    check({tag, "_addr44"}, {32'd0, d}, 64'd0);
    read_addr(6'd63, d);
    check({tag, "_addr63"}, {32'd0, d}, 64'd0);
  endtask

  // Loads a key and waits for keys_valid. rand_reads probes the buffer mid-expansion;
  // offer drives a competing key during expansion, which must be ignored.
  task automatic load_key(input logic [127:0] k, input bit rand_reads, input bit offer);
    int          n;
    logic [5:0]  a;
    build_model(k);
    check("key_ready_before_accept", {63'd0, bus.key_ready}, 64'd1);
    bus.key_valid = 1'b1;
    bus.key_in    = k;
    tick();
    bus.key_valid = 1'b0;
    check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
    check("key_ready_after_accept", {63'd0, bus.key_ready}, 64'd0);
    check("keys_valid_after_accept", {63'd0, bus.keys_valid}, 64'd0);
    n = 0;
    while (n < 60) begin
      n++;
      if (offer) begin
        bus.key_valid = (n >= 5 && n < 15);
        bus.key_in    = ~k;
      end
      a = rand_reads ? 6'($urandom_range(0, 63)) : 6'd0;
      bus.rk_addr = a;
      tick();
      if (offer && n >= 5 && n < 15) begin
        check("ready_low_while_offered", {63'd0, bus.key_ready}, 64'd0);
        check("busy_while_offered", {63'd0, bus.busy}, 64'd1);
      end
      if (rand_reads) begin
        if (a >= 6'd44) check("midread_oob", {32'd0, bus.rk_rdata}, 64'd0);
        else if (int'(a) < n + 3) check($sformatf("midread_addr%0d", a), {32'd0, bus.rk_rdata}, {32'd0, mk[a]});
      end
`ifdef SIMON_KS_STREAM_EN
      if (n <= 44) begin
        check("stream_valid", {63'd0, bus.rk_stream_valid}, 64'd1);
        check("stream_idx", {58'd0, bus.rk_stream_idx}, 64'(n - 1));
        check("stream_data", {32'd0, bus.rk_stream_data}, {32'd0, mk[n-1]});
      end
`endif
      if (bus.keys_valid) break;
    end
    bus.key_valid = 1'b0;
    check("accept_to_keys_valid_cycles", 64'(n), 64'd41);
`ifdef SIMON_KS_STREAM_EN
    while (n < 44) begin
      n++;
      tick();
      check("stream_valid_tail", {63'd0, bus.rk_stream_valid}, 64'd1);
      check("stream_idx_tail", {58'd0, bus.rk_stream_idx}, 64'(n - 1));
      check("stream_data_tail", {32'd0, bus.rk_stream_data}, {32'd0, mk[n-1]});
    end
    tick();
    check("stream_idle", {63'd0, bus.rk_stream_valid}, 64'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  d;
    logic [127:0] k;
    logic [127:0] cur;
    logic [5:0]   a;

    bus.key_valid = 1'b0;
    bus.key_in    = '0;
    bus.rk_addr   = '0;
    tick();
    tick();
    check("rst_key_ready", {63'd0, bus.key_ready}, 64'd1);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_keys_valid", {63'd0, bus.keys_valid}, 64'd0);
    check("rst_rk_rdata", {32'd0, bus.rk_rdata}, 64'd0);
    rst = 1'b0;
    tick();

    tbl[0] = '{KEY_REF,  6'd0,  32'h03020100};
    tbl[1] = '{KEY_REF,  6'd1,  32'h0b0a0908};
    tbl[2] = '{KEY_REF,  6'd2,  32'h13121110};
    tbl[3] = '{KEY_REF,  6'd3,  32'h1b1a1918};
    tbl[4] = '{KEY_REF,  6'd4,  32'h70a011c3};
    tbl[5] = '{KEY_REF,  6'd44, 32'h00000000};
    tbl[6] = '{KEY_REF,  6'd63, 32'h00000000};
    tbl[7] = '{KEY_ZERO, 6'd4,  32'hFFFFFFFD};
    tbl[8] = '{KEY_ZERO, 6'd0,  32'h00000000};
    tbl[9] = '{KEY_ZERO, 6'd3,  32'h00000000};
    cur = ~KEY_REF;
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].key !== cur) begin
        if (i != 0) check("keys_valid_before_restart", {63'd0, bus.keys_valid}, 64'd1);
        load_key(tbl[i].key, 1'b0, 1'b0);
        cur = tbl[i].key;
      end
      read_addr(tbl[i].addr, d);
      check($sformatf("vec%0d_addr%0d", i, tbl[i].addr), {32'd0, d}, {32'd0, tbl[i].exp});
    end
    sweep("zero_key");

    load_key(KEY_REF, 1'b0, 1'b0);
    sweep("ref_key");

    load_key(KEY_REF, 1'b0, 1'b1);
    read_addr(6'd4, d);
    check("offer_ignored_k4", {32'd0, d}, 64'h70a011c3);
    read_addr(6'd43, d);
    check("offer_ignored_k43", {32'd0, d}, {32'd0, mk[43]});

    bus.key_valid = 1'b1;
    bus.key_in    = {$urandom, $urandom, $urandom, $urandom};
    tick();
    bus.key_valid = 1'b0;
    repeat (20) tick();
    check("mid_expand_busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_keys_valid", {63'd0, bus.keys_valid}, 64'd0);
    check("midrst_key_ready", {63'd0, bus.key_ready}, 64'd1);
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k, 1'b0, 1'b0);
    sweep("after_rst");

    for (int r = 0; r < 4; r++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k, 1'b1, 1'b0);
      for (int j = 0; j < 12; j++) begin
        a = 6'($urandom_range(0, 63));
        read_addr(a, d);
        check($sformatf("rand%0d_addr%0d", r, a), {32'd0, d}, (a < 6'd44) ? {32'd0, mk[a]} : 64'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
